// File: rtl/traffic_light_controller.sv
// Two-road intersection controller: Moore FSM with green-while-traffic and fixed-length yellow.
// Light outputs are registered from the next-state decode, so they track the state register exactly.
module traffic_light_controller #(
  parameter int unsigned YELLOW_CYCLES    = 5,
  parameter int unsigned MIN_GREEN_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       traffic_A,
  input  logic       traffic_B,
  output logic [1:0] LA,
  output logic [1:0] LB
);

  localparam int unsigned CNT_MAX = (YELLOW_CYCLES > MIN_GREEN_CYCLES) ? YELLOW_CYCLES
                                                                       : MIN_GREEN_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  typedef enum logic [1:0] {
    S0_A_GREEN  = 2'd0,
    S1_A_YELLOW = 2'd1,
    S2_B_GREEN  = 2'd2,
    S3_B_YELLOW = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         la_q, la_d;
  logic [1:0]         lb_q, lb_d;

  // State, cycle counter and light registers
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    la_q    <= la_d;
    lb_q    <= lb_d;
  end

  // Next-state, counter and light decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    la_d    = RED;
    lb_d    = RED;

    if (reset) begin
      state_d = S0_A_GREEN;
    end else begin
      case (state_q)
        S0_A_GREEN:
          if (!traffic_A && (cnt_q >= CNT_W'(MIN_GREEN_CYCLES - 1))) state_d = S1_A_YELLOW;
        S1_A_YELLOW:
          if (cnt_q == CNT_W'(YELLOW_CYCLES - 1)) state_d = S2_B_GREEN;
        S2_B_GREEN:
          if (!traffic_B && (cnt_q >= CNT_W'(MIN_GREEN_CYCLES - 1))) state_d = S3_B_YELLOW;
        S3_B_YELLOW:
          if (cnt_q == CNT_W'(YELLOW_CYCLES - 1)) state_d = S0_A_GREEN;
        default:
          state_d = S0_A_GREEN;
      endcase
    end

    if (reset || (state_d != state_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Lights follow the state the register is about to hold
    case (state_d)
      S0_A_GREEN:  la_d = GREEN;
      S1_A_YELLOW: la_d = YELLOW;
      S2_B_GREEN:  lb_d = GREEN;
      S3_B_YELLOW: lb_d = YELLOW;
      default: begin
        la_d = RED;
        lb_d = RED;
      end
    endcase
  end

  assign LA = la_q;
  assign LB = lb_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller: a behavioural model feeds an expected-light
// scoreboard each cycle, with extra checks on phase lengths and light-safety rules.
module tb_traffic_light_controller;

  localparam int YEL = 5;
  localparam int MING = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       traffic_A;
  logic       traffic_B;
  logic [1:0] LA;
  logic [1:0] LB;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];

  // Model state: 0 A green, 1 A yellow, 2 B green, 3 B yellow; age = cycles spent in it
  int m_st  = 0;
  int m_age = 0;

  traffic_light_controller #(
    .YELLOW_CYCLES   (YEL),
    .MIN_GREEN_CYCLES(MING)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .traffic_A(traffic_A),
    .traffic_B(traffic_B),
    .LA       (LA),
    .LB       (LB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lights(input int st);
    case (st)
      0:       return 4'b00_10;
      1:       return 4'b01_10;
      2:       return 4'b10_00;
      default: return 4'b10_01;
    endcase
  endfunction

  task automatic model_edge(input logic a, input logic b, input logic r);
    int nxt;
    nxt = m_st;
    if (r) begin
      nxt = 0;
    end else begin
      case (m_st)
        0: if (!a && m_age >= MING - 1) nxt = 1;
        1: if (m_age == YEL - 1) nxt = 2;
        2: if (!b && m_age >= MING - 1) nxt = 3;
        default: if (m_age == YEL - 1) nxt = 0;
      endcase
    end
    if (r || nxt != m_st) m_age = 0;
    else m_age++;
    m_st = nxt;
  endtask

  // Drive one cycle, predict, advance the clock, then compare away from the edge
  task automatic step(input logic a, input logic b, input logic r);
    logic [3:0] e;
    traffic_A = a;
    traffic_B = b;
    reset     = r;
    model_edge(a, b, r);
    exp_q.push_back(lights(m_st));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("LA", 32'(LA), 32'(e[3:2]));
    chk("LB", 32'(LB), 32'(e[1:0]));
    chk("LA_not_11", 32'(LA == 2'b11), 32'd0);
    chk("LB_not_11", 32'(LB == 2'b11), 32'd0);
    chk("one_road_open", 32'((LA != 2'b10) && (LB != 2'b10)), 32'd0);
  endtask

  // Count consecutive cycles with light == val (first already seen), bounded
  task automatic count_run(input logic a, input logic b, input bit use_la,
                           input logic [1:0] val, output int len);
    len = 1;
    for (int i = 0; i < 30; i++) begin
      step(a, b, 1'b0);
      if ((use_la ? LA : LB) == val) len++;
      else break;
    end
  endtask

  initial begin
    int len;
    int c_ay, c_ag, c_bg;
    bit found;

    traffic_A = 1'b1;
    traffic_B = 1'b0;
    reset     = 1'b1;
    @(negedge clk);

    // 1: reset, then A traffic holds S0
    step(1'b1, 1'b0, 1'b1);
    chk("reset_LA", 32'(LA), 32'd0);
    chk("reset_LB", 32'(LB), 32'd2);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
    chk("hold_A_LA", 32'(LA), 32'd0);

    // 2: A drops -> 5-cycle A yellow, then B green
    step(1'b0, 1'b1, 1'b0);
    chk("A_yellow_start", 32'(LA), 32'd1);
    count_run(1'b0, 1'b1, 1'b1, 2'b01, len);
    chk("A_yellow_len", 32'(len), 32'd5);
    chk("B_green_LA", 32'(LA), 32'd2);
    chk("B_green_LB", 32'(LB), 32'd0);

    // 3: B traffic holds S2 for 10 cycles, then B yellow 5 cycles
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0);
    chk("hold_B_LB", 32'(LB), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("B_yellow_start", 32'(LB), 32'd1);
    count_run(1'b0, 1'b0, 1'b0, 2'b01, len);
    chk("B_yellow_len", 32'(len), 32'd5);
    chk("back_A_LA", 32'(LA), 32'd0);
    chk("back_A_LB", 32'(LB), 32'd2);

    // 4: idle sensors -> two full 12-cycle periods
    c_ay = 0; c_ag = 0; c_bg = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (LA == 2'b01) c_ay++;
      if (LA == 2'b00) c_ag++;
      if (LB == 2'b00) c_bg++;
    end
    chk("idle_A_yellow_cnt", 32'(c_ay), 32'd10);
    chk("idle_A_green_cnt", 32'(c_ag), 32'd2);
    chk("idle_B_green_cnt", 32'(c_bg), 32'd2);

    // 5: reset in third A-yellow cycle restarts the phase
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (LA == 2'b00) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_A_green", 32'(found), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("third_yellow", 32'(LA), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("midreset_LA", 32'(LA), 32'd0);
    chk("midreset_LB", 32'(LB), 32'd2);
    step(1'b0, 1'b0, 1'b0);
    chk("post_reset_yellow", 32'(LA), 32'd1);
    count_run(1'b0, 1'b0, 1'b1, 2'b01, len);
    chk("post_reset_yellow_len", 32'(len), 32'd5);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
